// File: rtl/pixel_pkg.sv
// pixel_pkg: shared FSM states, phase lengths, widths and photocurrent-to-step helper
package pixel_pkg;
   typedef enum logic [1:0] {ERASE, EXPOSE, CONVERT, READ} state_t;
   localparam int C_ERASE = 5;
   localparam int C_EXPOSE = 255;
   localparam int C_CONVERT = 256;
   localparam int CODE_W = 8;
   localparam int ACC_W = 16;
   localparam int CNT_W = 9;
   function automatic logic [8:0] step_of(input real dv);
      return dv <= 0.0 ? 9'd0 : dv >= 1.0 ? 9'd256 : 9'(int'(dv * 256.0));
   endfunction
endpackage

// File: rtl/pixel_sensor.sv
// pixel_sensor: one pixel (clk, reset, erase/expose/convert phase strobes, step, ramp in; code out) with accumulator, latch flag and ramp-ADC code register
module pixel_sensor
   import pixel_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              erase,
   input  logic              expose,
   input  logic              convert,
   input  logic [8:0]        step,
   input  logic [7:0]        ramp,
   output logic [CODE_W-1:0] code
);
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              lat_q, lat_d, hit;
   logic [CODE_W-1:0] code_q, code_d;
   always_comb begin
      acc_d = erase ? '0 : expose ? acc_q + ACC_W'(step) : acc_q;
      hit = convert && !lat_q && ramp >= acc_q[15:8];
      lat_d = erase ? 1'b0 : lat_q | hit;
      code_d = hit ? ramp : code_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
         lat_q <= 1'b0;
         code_q <= '0;
      end else begin
         acc_q <= acc_d;
         lat_q <= lat_d;
         code_q <= code_d;
      end
   end
   assign code = code_q;
endmodule

// File: rtl/pixel_top.sv
// pixel_top: HxW sensor array with frame FSM (clk, sync active-high reset in; pixelDataOut = all 8-bit codes, pixel i at [8i+7:8i])
module pixel_top
   import pixel_pkg::*;
#(
   parameter int  W = 3,
   parameter int  H = 2,
   parameter int  N = H * W,
   parameter real dv_pixel = 0.5
) (
   input  logic           clk,
   input  logic           reset,
   output logic [8*N-1:0] pixelDataOut
);
   localparam logic [8:0] STEP = step_of(dv_pixel);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       ramp_q, ramp_d;
   logic [8*N-1:0]   out_q, out_d, codes;
   logic             last;
   always_comb begin
      last = (state_q == ERASE && cnt_q == CNT_W'(C_ERASE - 1)) ||
             (state_q == EXPOSE && cnt_q == CNT_W'(C_EXPOSE - 1)) ||
             (state_q == CONVERT && cnt_q == CNT_W'(C_CONVERT - 1)) ||
             state_q == READ;
      state_d = last ? state_t'(state_q + 2'd1) : state_q;
      cnt_d = last ? '0 : cnt_q + 1'b1;
      ramp_d = state_q == CONVERT ? ramp_q + 1'b1 : '0;
      out_d = state_q == READ ? codes : out_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ERASE;
         cnt_q <= '0;
         ramp_q <= '0;
         out_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         ramp_q <= ramp_d;
         out_q <= out_d;
      end
   end
   for (genvar i = 0; i < N; i++) begin : g_px
      pixel_sensor u_px (
         .clk     (clk),
         .reset   (reset),
         .erase   (state_q == ERASE),
         .expose  (state_q == EXPOSE),
         .convert (state_q == CONVERT),
         .step    (STEP),
         .ramp    (ramp_q),
         .code    (codes[8*i+:8])
      );
   end
   assign pixelDataOut = out_q;
endmodule

// File: tb/tb_pixel_top.sv
// tb_pixel_top: scoreboard bench over five parameterisations of pixel_top sharing clock and reset
module tb_pixel_top;
   import pixel_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [47:0] out_a, out_b, out_c, out_d;
   logic [127:0] out_e;
   typedef struct {
      int at;
      logic [47:0] a, b, c, d;
      logic [127:0] e;
   } exp_t;
   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int cyc = -1;
   always #5 clk = ~clk;
   pixel_top #(.dv_pixel(0.5)) u_a (.clk(clk), .reset(reset), .pixelDataOut(out_a));
   pixel_top #(.dv_pixel(1.0)) u_b (.clk(clk), .reset(reset), .pixelDataOut(out_b));
   pixel_top #(.dv_pixel(0.0)) u_c (.clk(clk), .reset(reset), .pixelDataOut(out_c));
   pixel_top #(.dv_pixel(0.25)) u_d (.clk(clk), .reset(reset), .pixelDataOut(out_d));
   pixel_top #(.W(4), .H(4), .N(16), .dv_pixel(0.5)) u_e (.clk(clk), .reset(reset), .pixelDataOut(out_e));
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask
   task automatic push_frame(input int at);
      exp_t x;
      x.at = at;
      x.a = {6{8'h7F}};
      x.b = {6{8'hFF}};
      x.c = '0;
      x.d = {6{8'h3F}};
      x.e = {16{8'h7F}};
      sb.push_back(x);
   endtask
   task automatic run_to(input int last, input bit zero_before);
      exp_t x;
      while (cyc < last) begin
         tick();
         if (sb.size() > 0 && sb[0].at == cyc) begin
            x = sb.pop_front();
            checks += 5;
            if (out_a !== x.a) begin errors++; $display("FAIL frame_half cyc %0d got %h want %h", cyc, out_a, x.a); end
            if (out_b !== x.b) begin errors++; $display("FAIL frame_full cyc %0d got %h want %h", cyc, out_b, x.b); end
            if (out_c !== x.c) begin errors++; $display("FAIL frame_dark cyc %0d got %h want %h", cyc, out_c, x.c); end
            if (out_d !== x.d) begin errors++; $display("FAIL frame_quarter cyc %0d got %h want %h", cyc, out_d, x.d); end
            if (out_e !== x.e) begin errors++; $display("FAIL frame_4x4 cyc %0d got %h want %h", cyc, out_e, x.e); end
         end else if (zero_before) begin
            checks++;
            if (out_a !== 48'h0 || out_e !== 128'h0) begin
               errors++;
               $display("FAIL early_output cyc %0d got %h / %h want 0", cyc, out_a, out_e);
            end
         end
      end
   endtask
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      checks += 3;
      if ({out_a, out_b, out_c, out_d, out_e} !== '0) begin errors++; $display("FAIL reset_out got nonzero want 0"); end
      if (u_a.state_q !== ERASE) begin errors++; $display("FAIL reset_state got %0d want %0d", u_a.state_q, ERASE); end
      if (u_a.cnt_q !== 9'd0 || u_a.ramp_q !== 8'd0) begin
         errors++;
         $display("FAIL reset_counters got %0d/%0d want 0/0", u_a.cnt_q, u_a.ramp_q);
      end
      reset = 1'b0;
      cyc = -1;
   endtask
   task automatic test_first_frame();
      push_frame(516);
      run_to(516, 1'b1);
      checks += 3;
      if (u_c.state_q !== ERASE) begin errors++; $display("FAIL dark_state got %0d want %0d", u_c.state_q, ERASE); end
      if (out_e[7:0] !== 8'h7F) begin errors++; $display("FAIL byte_lo got %h want 7f", out_e[7:0]); end
      if (out_e[127:120] !== 8'h7F) begin errors++; $display("FAIL byte_hi got %h want 7f", out_e[127:120]); end
   endtask
   task automatic test_second_frame();
      run_to(800, 1'b0);
      checks++;
      if (out_a !== {6{8'h7F}}) begin errors++; $display("FAIL hold got %h want %h", out_a, {6{8'h7F}}); end
      push_frame(1033);
      run_to(1033, 1'b0);
   endtask
   task automatic test_mid_reset();
      run_to(1333, 1'b0);
      checks++;
      if (u_a.state_q !== CONVERT) begin errors++; $display("FAIL pre_reset_state got %0d want %0d", u_a.state_q, CONVERT); end
      reset = 1'b1;
      tick();
      checks += 2;
      if ({out_a, out_b, out_c, out_d, out_e} !== '0) begin errors++; $display("FAIL mid_reset_out got %h want 0", out_a); end
      if (u_a.state_q !== ERASE) begin errors++; $display("FAIL mid_reset_state got %0d want %0d", u_a.state_q, ERASE); end
      reset = 1'b0;
      cyc = -1;
      push_frame(516);
      run_to(516, 1'b1);
   endtask
   initial begin
      test_reset();
      test_first_frame();
      test_second_frame();
      test_mid_reset();
      checks++;
      if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
